// File: rtl/ntt_job_sequencer.sv
// -----------------------------------------------------------------------------
// ntt_job_sequencer
//
// Host-side controller for a single ntt_processor. It packs an incoming
// coefficient stream two at a time into {odd, even} words, writes them to the
// processor's input memory at consecutive addresses, pulses the processor
// start, then follows the processor's output phase until the expected number
// of result beats has gone by and reports job completion. The result data
// itself does not pass through this block.
//
// Optional feature (compile-time macro NTT_SEQ_TIMEOUT_EN):
//   defined   - a watchdog counts cycles spent in WAIT/DRAIN, cleared on every
//               active result beat. Hitting TIMEOUT sets the sticky error flag
//               and finishes the job (done still pulses).
//   undefined - no watchdog; error is tied low and WAIT/DRAIN wait forever.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   cmd_start         job request, honoured only while idle
//   busy              high in every state except IDLE and FIN
//   done              one-cycle pulse at job end
//   error             sticky watchdog flag (cleared by rst or accepted start)
//   s_valid/s_ready   coefficient stream handshake
//   s_data            coefficient, even index first
//   ntt_write_enable  processor memory write strobe
//   ntt_address_in    processor memory write address
//   ntt_data_in       packed word {coeff[2k+1], coeff[2k]}
//   ntt_start         one-cycle processor start pulse
//   ntt_output_active processor result-beat indicator
//   drain_valid       ntt_output_active qualified by the WAIT/DRAIN phase
// -----------------------------------------------------------------------------
module ntt_job_sequencer #(
  parameter int WORDS     = 2048,     // packed words per job, 2**ADDR_W
  parameter int ADDR_W    = 11,
  parameter int COEFF_W   = 30,
  parameter int OUT_BEATS = 64,
  parameter int TIMEOUT   = 1 << 20   // watchdog limit, NTT_SEQ_TIMEOUT_EN only
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [COEFF_W-1:0]   s_data,
  output logic                 ntt_write_enable,
  output logic [ADDR_W-1:0]    ntt_address_in,
  output logic [2*COEFF_W-1:0] ntt_data_in,
  output logic                 ntt_start,
  input  logic                 ntt_output_active,
  output logic                 drain_valid
);

  localparam int BEAT_W = $clog2(OUT_BEATS + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [BEAT_W-1:0] BEAT_END  = BEAT_W'(OUT_BEATS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_KICK  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [ADDR_W-1:0]    word_q,  word_d;   // next write address
  logic                 half_q,  half_d;   // even coefficient is held in lo_q
  logic [COEFF_W-1:0]   lo_q,    lo_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    addr_q,  addr_d;
  logic [2*COEFF_W-1:0] data_q,  data_d;
  logic [BEAT_W-1:0]    beat_q,  beat_d;
  logic [BEAT_W-1:0]    beat_inc;

  logic in_result_phase;

  assign beat_inc        = beat_q + 1'b1;
  assign in_result_phase = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

`ifdef NTT_SEQ_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_END = WDOG_W'(TIMEOUT);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [WDOG_W-1:0] wdog_inc;
  logic              error_q, error_d;

  assign wdog_inc = wdog_q + 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    half_d  = half_q;
    lo_d    = lo_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    beat_d  = beat_q;
`ifdef NTT_SEQ_TIMEOUT_EN
    wdog_d  = wdog_q;
    error_d = error_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d = ST_LOAD;
          word_d  = '0;
          half_d  = 1'b0;
`ifdef NTT_SEQ_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        // s_ready is constant high in LOAD, so s_valid alone is the handshake.
        if (s_valid) begin
          if (!half_q) begin
            lo_d   = s_data;
            half_d = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            addr_d  = word_q;
            data_d  = {s_data, lo_q};
            word_d  = word_q + 1'b1;
            half_d  = 1'b0;
          end
        end
        // Terminal condition is the final write actually on the bus, not the
        // word counter wrapping back to zero.
        if (wr_en_q && (addr_q == LAST_ADDR)) begin
          state_d = ST_KICK;
        end
      end

      ST_KICK: begin
        state_d = ST_WAIT;
        beat_d  = '0;
`ifdef NTT_SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end

      ST_WAIT, ST_DRAIN: begin
        if (ntt_output_active) begin
          // In WAIT beat_q is zero, so the first active cycle counts as beat 1.
          beat_d  = beat_inc;
          state_d = (beat_inc == BEAT_END) ? ST_FIN : ST_DRAIN;
`ifdef NTT_SEQ_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
`ifdef NTT_SEQ_TIMEOUT_EN
        else begin
          wdog_d = wdog_inc;
          if (wdog_inc == WDOG_END) begin
            state_d = ST_FIN;
            error_d = 1'b1;
          end
        end
`endif
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      half_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      half_q  <= half_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: the held even coefficient is pure datapath; half_q guards every use
  // of it, so it needs no reset.
  always_ff @(posedge clk) begin
    lo_q <= lo_d;
  end

`ifdef NTT_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Control outputs are decodes of the state register.
  assign busy             = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done             = (state_q == ST_FIN);
  assign s_ready          = (state_q == ST_LOAD);
  assign ntt_start        = (state_q == ST_KICK);
  assign ntt_write_enable = wr_en_q;
  assign ntt_address_in   = addr_q;
  assign ntt_data_in      = data_q;
  assign drain_valid      = ntt_output_active && in_result_phase;

endmodule

// File: tb/tb_ntt_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ntt_job_sequencer
//
// Directed bench for ntt_job_sequencer. Inputs change on the falling edge and
// outputs are compared 1 time unit later, so each "cycle" below is the
// interval between two rising edges. A short table covers the first cycles of
// a job; hand-written tasks cover full loads, backpressure, drain, mid-job
// reset and the watchdog.
// -----------------------------------------------------------------------------
module tb_ntt_job_sequencer;

  localparam int COEFF_W   = 30;
  localparam int ADDR_W    = 11;
  localparam int WORDS     = 2048;
  localparam int OUT_BEATS = 64;
  localparam int TIMEOUT   = 16;
  localparam int N_COEFF   = 2 * WORDS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cmd_start = 1'b0;
  logic                 s_valid = 1'b0;
  logic [COEFF_W-1:0]   s_data = '0;
  logic                 ntt_output_active = 1'b0;
  logic                 busy, done, error, s_ready;
  logic                 ntt_write_enable, ntt_start, drain_valid;
  logic [ADDR_W-1:0]    ntt_address_in;
  logic [2*COEFF_W-1:0] ntt_data_in;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int exp_done = 0;

  ntt_job_sequencer #(
    .WORDS     (WORDS),
    .ADDR_W    (ADDR_W),
    .COEFF_W   (COEFF_W),
    .OUT_BEATS (OUT_BEATS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_start         (cmd_start),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .ntt_write_enable  (ntt_write_enable),
    .ntt_address_in    (ntt_address_in),
    .ntt_data_in       (ntt_data_in),
    .ntt_start         (ntt_start),
    .ntt_output_active (ntt_output_active),
    .drain_valid       (drain_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) n_done++;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 5000000");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic                 rst;
    logic                 cmd;
    logic                 valid;
    logic [COEFF_W-1:0]   data;
    logic                 act;
    logic                 exp_busy;
    logic                 exp_ready;
    logic                 exp_wr;
    logic [ADDR_W-1:0]    exp_addr;
    logic [2*COEFF_W-1:0] exp_data;
    logic                 exp_dv;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [2*COEFF_W-1:0] pair(input int k);
    return {COEFF_W'(2 * k + 1), COEFF_W'(2 * k)};
  endfunction

  function automatic vec_t mk(input logic r, input logic c, input logic v, input int d,
                              input logic a, input logic eb, input logic er, input logic ew,
                              input int ea, input logic [2*COEFF_W-1:0] ed, input logic edv);
    vec_t t;
    t.rst = r; t.cmd = c; t.valid = v; t.data = COEFF_W'(d); t.act = a;
    t.exp_busy = eb; t.exp_ready = er; t.exp_wr = ew;
    t.exp_addr = ADDR_W'(ea); t.exp_data = ed; t.exp_dv = edv;
    return t;
  endfunction

  // One job's load phase: coefficient i = i, s_valid every gap-th cycle.
  // cmd_start is pulsed mid-load and must be ignored. With abort_at >= 0 the
  // job is reset right after the write to that address.
  task automatic run_load(input int gap, input int abort_at);
    int   i, cyc, k, bad_wr, bad_ctl, last_addr;
    logic pend;
    i = 0; cyc = 0; k = 0; bad_wr = 0; bad_ctl = 0; last_addr = -1; pend = 1'b0;
    tick();
    cmd_start = 1'b1; s_valid = 1'b0; ntt_output_active = 1'b0;
    #1;
    check("load_idle_busy", 64'(busy), 64'd0);
    while (i < N_COEFF || pend) begin
      tick();
      cmd_start         = (cyc == 7);
      s_valid           = (i < N_COEFF) && (cyc % gap == 0);
      s_data            = COEFF_W'(i);
      ntt_output_active = (cyc % 5 == 0);
      #1;
      if (s_ready !== 1'b1 || busy !== 1'b1 || drain_valid !== 1'b0 ||
          ntt_start !== 1'b0 || done !== 1'b0) bad_ctl++;
      if (ntt_write_enable !== pend) begin
        bad_wr++;
      end else if (pend) begin
        if (ntt_address_in !== ADDR_W'(k) || ntt_data_in !== pair(k)) bad_wr++;
        last_addr = int'(ntt_address_in);
        k++;
      end
      if (abort_at >= 0 && pend && (k - 1) == abort_at) begin
        check("abort_writes", 64'(bad_wr), 64'd0);
        tick();
        rst = 1'b1; cmd_start = 1'b0; s_valid = 1'b1;
        #1;
        tick();
        rst = 1'b0; s_valid = 1'b0; ntt_output_active = 1'b0;
        #1;
        check("abort_wr_en", 64'(ntt_write_enable), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_start", 64'(ntt_start), 64'd0);
        return;
      end
      pend = s_valid && (i % 2 == 1);
      if (s_valid) i++;
      cyc++;
    end
    check("load_bad_writes", 64'(bad_wr), 64'd0);
    check("load_ctl", 64'(bad_ctl), 64'd0);
    check("load_write_count", 64'(k), 64'(WORDS));
    check("load_last_addr", 64'(last_addr), 64'(WORDS - 1));
    tick();
    cmd_start = 1'b0; s_valid = 1'b0; ntt_output_active = 1'b0;
    #1;
    check("kick_start", 64'(ntt_start), 64'd1);
    check("kick_wr_en", 64'(ntt_write_enable), 64'd0);
    check("kick_ready", 64'(s_ready), 64'd0);
    check("kick_busy", 64'(busy), 64'd1);
  endtask

  // Result phase: pre idle cycles, on1 active, off gap, on2 active.
  // on1 + on2 must equal OUT_BEATS.
  task automatic run_drain(input int pre, input int on1, input int off, input int on2);
    int   bad, dv_cnt;
    logic a;
    bad = 0; dv_cnt = 0;
    for (int j = 0; j < pre; j++) begin
      tick();
      ntt_output_active = 1'b0;
      #1;
      if (drain_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || ntt_start !== 1'b0) bad++;
    end
    for (int j = 0; j < on1 + off + on2; j++) begin
      a = (j < on1) || (j >= on1 + off);
      tick();
      ntt_output_active = a;
      #1;
      if (drain_valid !== a || done !== 1'b0 || busy !== 1'b1) bad++;
      if (drain_valid === 1'b1) dv_cnt++;
    end
    check("drain_ctl", 64'(bad), 64'd0);
    check("drain_valid_count", 64'(dv_cnt), 64'(OUT_BEATS));
    tick();
    ntt_output_active = 1'b1; cmd_start = 1'b1;
    #1;
    check("fin_done", 64'(done), 64'd1);
    check("fin_busy", 64'(busy), 64'd0);
    check("fin_drain_valid", 64'(drain_valid), 64'd0);
    check("fin_error", 64'(error), 64'd0);
    exp_done++;
    tick();
    ntt_output_active = 1'b0; cmd_start = 1'b0;
    #1;
    check("post_fin_done", 64'(done), 64'd0);
    check("post_fin_busy", 64'(busy), 64'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = mk(0, 1, 0,  0, 1, 0, 0, 0, 0, '0,       0);
    vecs[1]  = mk(0, 0, 1,  5, 1, 1, 1, 0, 0, '0,       0);
    vecs[2]  = mk(0, 1, 1,  7, 0, 1, 1, 0, 0, '0,       0);
    vecs[3]  = mk(0, 0, 0,  0, 0, 1, 1, 1, 0, {30'd7, 30'd5},   0);
    vecs[4]  = mk(0, 0, 1,  9, 0, 1, 1, 0, 0, '0,       0);
    vecs[5]  = mk(0, 0, 0,  0, 1, 1, 1, 0, 0, '0,       0);
    vecs[6]  = mk(0, 0, 1, 11, 0, 1, 1, 0, 0, '0,       0);
    vecs[7]  = mk(0, 0, 0,  0, 0, 1, 1, 1, 1, {30'd11, 30'd9},  0);
    vecs[8]  = mk(1, 0, 1, 13, 0, 1, 1, 0, 0, '0,       0);
    vecs[9]  = mk(0, 0, 0,  0, 1, 0, 0, 0, 0, '0,       0);
    vecs[10] = mk(0, 0, 1,  3, 0, 0, 0, 0, 0, '0,       0);

    // Reset with random inputs: after one edge in reset everything is low.
    for (int j = 0; j < 2; j++) begin
      tick();
      rst = 1'b1;
      cmd_start = 1'($urandom); s_valid = 1'($urandom);
      s_data = COEFF_W'($urandom); ntt_output_active = 1'($urandom);
      #1;
      if (j == 1) begin
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_wr_en", 64'(ntt_write_enable), 64'd0);
        check("rst_addr", 64'(ntt_address_in), 64'd0);
        check("rst_data", 64'(ntt_data_in), 64'd0);
        check("rst_start", 64'(ntt_start), 64'd0);
        check("rst_drain_valid", 64'(drain_valid), 64'd0);
      end
    end
    tick();
    rst = 1'b0; cmd_start = 1'b0; s_valid = 1'b0; ntt_output_active = 1'b0;
    #1;
    check("idle_busy", 64'(busy), 64'd0);

    // Cycle-accurate start of a job, a short mid-load reset, then idle.
    foreach (vecs[n]) begin
      tick();
      rst = vecs[n].rst; cmd_start = vecs[n].cmd; s_valid = vecs[n].valid;
      s_data = vecs[n].data; ntt_output_active = vecs[n].act;
      #1;
      check($sformatf("vec%0d_busy", n), 64'(busy), 64'(vecs[n].exp_busy));
      check($sformatf("vec%0d_ready", n), 64'(s_ready), 64'(vecs[n].exp_ready));
      check($sformatf("vec%0d_wr_en", n), 64'(ntt_write_enable), 64'(vecs[n].exp_wr));
      check($sformatf("vec%0d_drain_valid", n), 64'(drain_valid), 64'(vecs[n].exp_dv));
      check($sformatf("vec%0d_start", n), 64'(ntt_start), 64'd0);
      if (vecs[n].exp_wr) begin
        check($sformatf("vec%0d_addr", n), 64'(ntt_address_in), 64'(vecs[n].exp_addr));
        check($sformatf("vec%0d_data", n), 64'(ntt_data_in), 64'(vecs[n].exp_data));
      end
    end

    // Full-rate job with a gapped result phase.
    run_load(1, -1);
    run_drain(5, 30, 3, 34);

    // Backpressured job: one coefficient every third cycle.
    run_load(3, -1);
    run_drain(0, 64, 0, 0);

    // Reset after address 100, then a fresh job must restart at address 0.
    run_load(1, 100);
    run_load(2, -1);
    run_drain(2, 10, 5, 54);

    // Watchdog behaviour.
    run_load(1, -1);
`ifdef NTT_SEQ_TIMEOUT_EN
    begin
      int bad;
      bad = 0;
      for (int j = 0; j < TIMEOUT; j++) begin
        tick();
        ntt_output_active = 1'b0;
        #1;
        if (done !== 1'b0 || error !== 1'b0) bad++;
      end
      check("wdog_early", 64'(bad), 64'd0);
      tick();
      #1;
      check("wdog_done", 64'(done), 64'd1);
      check("wdog_error", 64'(error), 64'd1);
      exp_done++;
      tick();
      cmd_start = 1'b1;
      #1;
      check("wdog_error_sticky", 64'(error), 64'd1);
      tick();
      cmd_start = 1'b0;
      #1;
      check("wdog_error_cleared", 64'(error), 64'd0);
      check("wdog_new_job_busy", 64'(busy), 64'd1);
    end
`else
    for (int j = 0; j < 1000; j++) begin
      tick();
      ntt_output_active = 1'b0;
      #1;
    end
    check("no_wdog_busy", 64'(busy), 64'd1);
    check("no_wdog_error", 64'(error), 64'd0);
`endif
    tick();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
    check("final_busy", 64'(busy), 64'd0);
    tick();
    #1;
    check("done_pulse_count", 64'(n_done), 64'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
